memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Arbitrates the pipeline's instruction-fetch and data-access ports onto one single-ported RAM. It sits between the datapath/caches and the RAM and produces the `ihit` and `dhit` strobes that the hazard unit consumes to advance or stall the pipe. Data accesses win over instruction fetches, but an access in flight always completes before the next one starts. A wait-cycle watchdog and RAM error reporting set a sticky bus-error flag.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 64: maximum wait cycles per access before abort; must be ≥2.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iREN`  in  1  instruction fetch request.
- `iaddr`  in  AW  fetch address.
- `ihit`  out  1  fetch complete this cycle.
- `iload`  out  DW  fetched word; valid only when `ihit`=1.
- `dREN`  in  1  data read request.
- `dWEN`  in  1  data write request.
- `daddr`  in  AW  data address.
- `dstore`  in  DW  write data.
- `dhit`  out  1  data access complete this cycle.
- `dload`  out  DW  read word; valid only when `dhit`=1.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  AW  RAM address.
- `ramstore`  out  DW  RAM write data.
- `ramload`  in  DW  RAM read data.
- `ramstate`  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- `buserr`  out  1  sticky error flag; cleared only by `RST`.

## Operation
- States: IDLE, DATA, INSTR. Reset state is IDLE.
- IDLE:
  - No RAM strobes; `ramaddr` = 0, `ramstore` = 0.
  - If `dREN|dWEN`, go to DATA. Otherwise, if `iREN`, go to INSTR. Otherwise stay in IDLE.
- DATA:
  - `ramREN` = `dREN`, `ramWEN` = `dWEN`, `ramaddr` = `daddr`, `ramstore` = `dstore`. These follow the live inputs.
  - If `ramstate`==ACCESS: `dhit` = 1 and `dload` = `ramload` (combinational), then go to IDLE.
- INSTR:
  - `ramREN` = `iREN`, `ramWEN` = 0, `ramaddr` = `iaddr`.
  - If `ramstate`==ACCESS: `ihit` = 1 and `iload` = `ramload`, then go to IDLE.
- No preemption: a data request that arrives while in INSTR waits until the fetch completes.
- Abort: if the owning request drops while in DATA or INSTR (DATA: `dREN|dWEN`=0; INSTR: `iREN`=0), go to IDLE with no hit and no error. Strobes are already 0 that cycle, because they follow the inputs.
- `dREN` and `dWEN` both high: drive both strobes through unchanged; RAM behaviour in that case is RAM-defined. `dhit` still completes the access.
- `ramstate`==ERROR in DATA or INSTR: set `buserr`, no hit, go to IDLE.
- Watchdog `wcnt` (width ceil(log2(TIMEOUT))+1):
  - Cleared in IDLE and on every transition out of DATA or INSTR.
  - Increments each cycle in DATA or INSTR when `ramstate` is neither ACCESS nor ERROR.
  - When `wcnt`==TIMEOUT−1 and the access is still not complete, set `buserr`, no hit, go to IDLE.
- ACCESS and the timeout condition in the same cycle: ACCESS wins, the hit is issued and no error is set.
- `ihit` and `dhit` are never high in the same cycle.

## Timing
- Reset values: state IDLE; `wcnt` 0; `buserr` 0. All outputs are 0: `ihit`, `dhit`, `iload`, `dload`, all `ram*` outputs.
- `iload` and `dload` are 0 whenever their hit is 0.
- Minimum latency is 1 cycle: request sampled in IDLE at edge N, RAM driven in cycle N+1, hit in cycle N+1 if ACCESS.
- Back-to-back accesses have one mandatory IDLE cycle between them. Peak throughput is 1 access per 2 cycles.
- Request inputs must be held stable until the hit. Changing the address mid-access is forwarded to the RAM unchanged.
- `RST` mid-access: the next cycle is IDLE with all strobes 0. No hit is produced for the aborted access, and `buserr` is cleared.

## Test plan
- Read: `dREN`=1, `daddr`=0x40, RAM returns ACCESS on its 3rd driven cycle with `ramload`=0xDEADBEEF -> `dhit`=1 for exactly 1 cycle with `dload`=0xDEADBEEF; `ihit` stays 0.
- Conflict: `iREN`=1 (`iaddr`=0x100) and `dWEN`=1 (`daddr`=0x80, `dstore`=0x1234) raised in the same IDLE cycle -> data is serviced first with `ramWEN`=1, `ramaddr`=0x80; one IDLE cycle; then the fetch with `ramaddr`=0x100, `ihit`=1.
- No preemption: fetch in flight with RAM BUSY, then `dREN` asserted -> fetch completes (`ihit`) first, then IDLE, then DATA.
- Timeout: TIMEOUT=4, RAM held BUSY -> after 4 cycles in DATA, `buserr`=1, state IDLE, no `dhit`. `buserr` stays 1 through later successful accesses until `RST`.
- Error and abort: `ramstate`=ERROR on the 1st driven cycle -> `buserr`=1, no hit. Separately, `iREN` dropped mid-fetch -> IDLE next cycle, no hit, `buserr` unchanged.
- Reset: `RST` pulsed while in DATA with RAM BUSY -> next cycle all outputs 0, state IDLE. A new `dREN` then completes normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one single-ported RAM between the instruction-fetch port and the
// data-access port. Data requests win over fetches when both are raised in
// the same IDLE cycle, but an access that has already started is never
// preempted. Every access is followed by one IDLE cycle. A wait-cycle
// watchdog and the RAM ERROR status both set a sticky bus-error flag.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         instruction fetch request and address
//   ihit, iload         fetch complete strobe and fetched word
//   dREN, dWEN          data read / write request
//   daddr, dstore       data address and write data
//   dhit, dload         data access complete strobe and read word
//   ramREN, ramWEN      RAM read / write strobes
//   ramaddr, ramstore   RAM address and write data
//   ramload, ramstate   RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   buserr              sticky bus error, cleared only by RST
//
// The RAM-side strobes, address and the hit strobes are combinational from
// the registered state and the live request inputs, so a request sampled in
// IDLE at one edge can complete in the very next cycle.
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          ihit,
    output logic [DW-1:0] iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          dhit,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          buserr
);

    localparam int WCW = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           buserr_q, buserr_d;

    logic           d_req_s;
    logic           own_req_s;
    logic           ram_done_s;
    logic           ram_err_s;

    assign d_req_s    = dREN | dWEN;
    assign ram_done_s = (ramstate == RAM_ACCESS);
    assign ram_err_s  = (ramstate == RAM_ERROR);

    // Request that owns the RAM in the current state; dropping it aborts.
    always_comb begin
        own_req_s = 1'b0;
        case (state_q)
            DATA:    own_req_s = d_req_s;
            INSTR:   own_req_s = iREN;
            IDLE:    own_req_s = 1'b0;
            default: own_req_s = 1'b0;
        endcase
    end

    // Next-state, watchdog and sticky error logic.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        buserr_d = buserr_q;
        case (state_q)
            IDLE: begin
                wcnt_d = {WCW{1'b0}};
                if (d_req_s) begin
                    state_d = DATA;
                end else if (iREN) begin
                    state_d = INSTR;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA, INSTR: begin
                // Abort beats completion: the strobes are already low when
                // the owner drops, so the RAM did not see an access.
                if (!own_req_s) begin
                    state_d = IDLE;
                    wcnt_d  = {WCW{1'b0}};
                end else if (ram_done_s) begin
                    // ACCESS wins over a coincident watchdog expiry.
                    state_d = IDLE;
                    wcnt_d  = {WCW{1'b0}};
                end else if (ram_err_s) begin
                    state_d  = IDLE;
                    wcnt_d   = {WCW{1'b0}};
                    buserr_d = 1'b1;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d  = IDLE;
                    wcnt_d   = {WCW{1'b0}};
                    buserr_d = 1'b1;
                end else begin
                    state_d = state_q;
                    wcnt_d  = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = {WCW{1'b0}};
            end
        endcase
    end

    // RAM-side drive and hit strobes, following the live request inputs.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = {AW{1'b0}};
        ramstore = {DW{1'b0}};
        ihit     = 1'b0;
        iload    = {DW{1'b0}};
        dhit     = 1'b0;
        dload    = {DW{1'b0}};
        case (state_q)
            DATA: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (d_req_s && ram_done_s) begin
                    dhit  = 1'b1;
                    dload = ramload;
                end else begin
                    dhit  = 1'b0;
                    dload = {DW{1'b0}};
                end
            end
            INSTR: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ram_done_s) begin
                    ihit  = 1'b1;
                    iload = ramload;
                end else begin
                    ihit  = 1'b0;
                    iload = {DW{1'b0}};
                end
            end
            IDLE: begin
                ramREN = 1'b0;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign buserr = buserr_q;

    // State, watchdog and error registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            wcnt_q   <= {WCW{1'b0}};
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            buserr_q <= buserr_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TIMEOUT = 4;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          ihit;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dhit;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;
    logic          buserr;

    int checks = 0;
    int failures = 0;

    memory_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .buserr(buserr)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    endtask

    task automatic test_reset();
        RST = 1'b1; clear_inputs();
        cyc(); cyc(); #1;
        checks++;
        if ({ihit, dhit, ramREN, ramWEN, buserr} !== 5'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=00000", {ihit, dhit, ramREN, ramWEN, buserr});
        end
        checks++;
        if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
            failures++; $display("FAIL reset_buses got=%h exp=0", {iload, dload, ramaddr, ramstore});
        end
        cyc(); RST = 1'b0;
    endtask

    task automatic test_read();
        cyc(); dREN = 1'b1; daddr = 32'h40; #1;
        checks++;
        if ({ramREN, dhit} !== 2'b00) begin
            failures++; $display("FAIL read_idle got=%b exp=00", {ramREN, dhit});
        end
        cyc(); ramstate = BUSY; #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, dhit} !== {2'b10, 32'h40, 1'b0}) begin
            failures++; $display("FAIL read_drive1 got=%b/%h/%b", {ramREN, ramWEN}, ramaddr, dhit);
        end
        cyc(); #1;
        checks++;
        if (dhit !== 1'b0) begin
            failures++; $display("FAIL read_wait dhit got=%b exp=0", dhit);
        end
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        checks++;
        if ({dhit, ihit, dload} !== {2'b10, 32'hDEADBEEF}) begin
            failures++; $display("FAIL read_hit got=%b%b/%h exp=10/deadbeef", dhit, ihit, dload);
        end
        cyc(); dREN = 1'b0; ramstate = FREE; #1;
        checks++;
        if ({dhit, ramREN, dload} !== {2'b00, 32'h0}) begin
            failures++; $display("FAIL read_after got=%b%b/%h exp=00/0", dhit, ramREN, dload);
        end
        clear_inputs();
    endtask

    task automatic test_conflict();
        cyc(); iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; #1;
        cyc(); ramstate = ACCESS; ramload = 32'h5555AAAA; #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== {2'b01, 32'h80, 32'h1234}) begin
            failures++; $display("FAIL conflict_data_drive got=%b/%h/%h", {ramREN, ramWEN}, ramaddr, ramstore);
        end
        checks++;
        if ({dhit, ihit} !== 2'b10) begin
            failures++; $display("FAIL conflict_data_hit got=%b exp=10", {dhit, ihit});
        end
        cyc(); dWEN = 1'b0; ramstate = FREE; #1;
        checks++;
        if ({ramREN, ramWEN, ihit, dhit, ramaddr} !== {4'b0, 32'h0}) begin
            failures++; $display("FAIL conflict_gap got=%b/%h exp=0000/0", {ramREN, ramWEN, ihit, dhit}, ramaddr);
        end
        cyc(); ramstate = ACCESS; ramload = 32'hCAFE0001; #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, ihit, dhit, iload} !== {2'b10, 32'h100, 2'b10, 32'hCAFE0001}) begin
            failures++; $display("FAIL conflict_fetch got=%b/%h/%b/%h", {ramREN, ramWEN}, ramaddr, {ihit, dhit}, iload);
        end
        cyc(); clear_inputs();
    endtask

    task automatic test_no_preempt();
        cyc(); iREN = 1'b1; iaddr = 32'h200; #1;
        cyc(); ramstate = BUSY; dREN = 1'b1; daddr = 32'h44; #1;
        checks++;
        if ({ramREN, ramaddr, ihit, dhit} !== {1'b1, 32'h200, 2'b00}) begin
            failures++; $display("FAIL nopre_fetch_busy got=%b/%h/%b", ramREN, ramaddr, {ihit, dhit});
        end
        cyc(); ramstate = ACCESS; ramload = 32'h11112222; #1;
        checks++;
        if ({ihit, dhit, iload, ramaddr} !== {2'b10, 32'h11112222, 32'h200}) begin
            failures++; $display("FAIL nopre_fetch_hit got=%b/%h/%h", {ihit, dhit}, iload, ramaddr);
        end
        cyc(); iREN = 1'b0; ramstate = FREE; #1;
        checks++;
        if ({ramREN, ihit, dhit} !== 3'b000) begin
            failures++; $display("FAIL nopre_gap got=%b exp=000", {ramREN, ihit, dhit});
        end
        cyc(); ramstate = ACCESS; ramload = 32'h33334444; #1;
        checks++;
        if ({dhit, ihit, dload, ramaddr} !== {2'b10, 32'h33334444, 32'h44}) begin
            failures++; $display("FAIL nopre_data_hit got=%b/%h/%h", {dhit, ihit}, dload, ramaddr);
        end
        cyc(); clear_inputs();
    endtask

    task automatic test_rw_both();
        cyc(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h8; dstore = 32'h77; #1;
        cyc(); ramstate = ACCESS; ramload = 32'h99; #1;
        checks++;
        if ({ramREN, ramWEN, dhit, dload} !== {3'b111, 32'h99}) begin
            failures++; $display("FAIL rw_both got=%b/%h exp=111/99", {ramREN, ramWEN, dhit}, dload);
        end
        cyc(); clear_inputs();
    endtask

    task automatic test_error_abort();
        cyc(); dREN = 1'b1; daddr = 32'h10; #1;
        cyc(); ramstate = ERROR; #1;
        checks++;
        if ({dhit, ihit, buserr} !== 3'b000) begin
            failures++; $display("FAIL err_cycle got=%b exp=000", {dhit, ihit, buserr});
        end
        cyc(); dREN = 1'b0; ramstate = FREE; #1;
        checks++;
        if ({buserr, ramREN, dhit} !== 3'b100) begin
            failures++; $display("FAIL err_sticky got=%b exp=100", {buserr, ramREN, dhit});
        end
        // Clear the error before the abort scenario.
        cyc(); RST = 1'b1; cyc(); RST = 1'b0; #1;
        checks++;
        if (buserr !== 1'b0) begin
            failures++; $display("FAIL err_reset_clear got=%b exp=0", buserr);
        end
        cyc(); iREN = 1'b1; iaddr = 32'h300; #1;
        cyc(); ramstate = BUSY; #1;
        checks++;
        if ({ramREN, ihit} !== 2'b10) begin
            failures++; $display("FAIL abort_drive got=%b exp=10", {ramREN, ihit});
        end
        cyc(); iREN = 1'b0; #1;
        checks++;
        if ({ramREN, ihit} !== 2'b00) begin
            failures++; $display("FAIL abort_drop got=%b exp=00", {ramREN, ihit});
        end
        // Re-raise the fetch: an IDLE cycle proves the abort happened.
        cyc(); iREN = 1'b1; #1;
        checks++;
        if ({ramREN, ihit, buserr} !== 3'b000) begin
            failures++; $display("FAIL abort_idle got=%b exp=000", {ramREN, ihit, buserr});
        end
        cyc(); ramstate = ACCESS; ramload = 32'hABCD; #1;
        checks++;
        if ({ihit, iload} !== {1'b1, 32'hABCD}) begin
            failures++; $display("FAIL abort_refetch got=%b/%h exp=1/abcd", ihit, iload);
        end
        cyc(); clear_inputs();
    endtask

    task automatic test_access_at_timeout();
        cyc(); dREN = 1'b1; daddr = 32'h60; #1;
        cyc(); ramstate = BUSY;
        cyc(); cyc();
        cyc(); ramstate = ACCESS; ramload = 32'h600D; #1;
        checks++;
        if ({dhit, buserr, dload} !== {2'b10, 32'h600D}) begin
            failures++; $display("FAIL access_at_timeout got=%b/%h exp=10/600d", {dhit, buserr}, dload);
        end
        cyc(); dREN = 1'b0; ramstate = FREE; #1;
        checks++;
        if (buserr !== 1'b0) begin
            failures++; $display("FAIL access_at_timeout_err got=%b exp=0", buserr);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int hits;
        hits = 0;
        cyc(); dREN = 1'b1; daddr = 32'h50; #1;
        for (int k = 0; k < 4; k++) begin
            cyc(); ramstate = BUSY; #1;
            if (dhit !== 1'b0 || ramREN !== 1'b1 || buserr !== 1'b0) hits++;
        end
        checks++;
        if (hits !== 0) begin
            failures++; $display("FAIL timeout_wait bad_cycles got=%0d exp=0", hits);
        end
        cyc(); #1;
        checks++;
        if ({buserr, ramREN, dhit} !== 3'b100) begin
            failures++; $display("FAIL timeout_abort got=%b exp=100", {buserr, ramREN, dhit});
        end
        cyc(); ramstate = ACCESS; ramload = 32'h0F0F; #1;
        checks++;
        if ({dhit, buserr, dload} !== {2'b11, 32'h0F0F}) begin
            failures++; $display("FAIL timeout_sticky got=%b/%h exp=11/f0f", {dhit, buserr}, dload);
        end
        cyc(); clear_inputs();
    endtask

    task automatic test_reset_mid();
        cyc(); dREN = 1'b1; daddr = 32'h70; dstore = 32'h5; #1;
        cyc(); ramstate = BUSY; RST = 1'b1; #1;
        cyc(); RST = 1'b0; #1;
        checks++;
        if ({ramREN, ramWEN, dhit, ihit, buserr} !== 5'b0 || {ramaddr, ramstore, dload, iload} !== 128'h0) begin
            failures++; $display("FAIL reset_mid got=%b/%h exp=00000/0", {ramREN, ramWEN, dhit, ihit, buserr}, ramaddr);
        end
        cyc(); ramstate = ACCESS; ramload = 32'h7777; #1;
        checks++;
        if ({dhit, ramaddr, dload} !== {1'b1, 32'h70, 32'h7777}) begin
            failures++; $display("FAIL reset_mid_redo got=%b/%h/%h", dhit, ramaddr, dload);
        end
        cyc(); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_read();
        test_conflict();
        test_no_preempt();
        test_rw_both();
        test_error_abort();
        test_access_at_timeout();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
